regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_register_en.sv | 15 +
 rtl/regfile.sv | 52 +++++
 tb/tb_regfile.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file and ALU constants.
// Sizing and the zero-register index live here so the datapath agrees on them.
package regfile_pkg;
  localparam int REG_WIDTH = 32;
  localparam int REG_NREGS = 32;
  localparam int REG_IDX_W = $clog2(REG_NREGS);
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  // ALU control codes consumed by the execute stage fed from rs_data/rt_data.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;
endpackage

// File: rtl/regfile_register_en.sv
// WIDTH-bit register with load enable and asynchronous active-high clear.
module register_en #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file; register 0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward rd_data to a read of rd_num in the write cycle.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int NREGS = REG_NREGS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rs_num,
  input  logic [REG_IDX_W-1:0] rt_num,
  input  logic [REG_IDX_W-1:0] rd_num,
  input  logic [WIDTH-1:0]     rd_data,
  input  logic                 rd_we,
  output logic [WIDTH-1:0]     rs_data,
  output logic [WIDTH-1:0]     rt_data
);
  logic [WIDTH-1:0] regs [1:NREGS-1];
  logic [WIDTH-1:0] rs_mux;
  logic [WIDTH-1:0] rt_mux;

  // Index 0 has no storage, so writes to it simply have nowhere to land.
  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    register_en #(.WIDTH(WIDTH)) u_reg (
      .clock (clock),
      .reset (reset),
      .en    (rd_we && (rd_num == REG_IDX_W'(i))),
      .d     (rd_data),
      .q     (regs[i])
    );
  end

  always_comb begin
    rs_mux = '0;
    rt_mux = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs_num == REG_IDX_W'(i)) rs_mux = regs[i];
      if (rt_num == REG_IDX_W'(i)) rt_mux = regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok  = rd_we && (rd_num != REG_ZERO) && !reset;
  assign rs_data = (fwd_ok && (rs_num == rd_num)) ? rd_data : rs_mux;
  assign rt_data = (fwd_ok && (rt_num == rd_num)) ? rd_data : rt_mux;
`else
  assign rs_data = rs_mux;
  assign rt_data = rt_mux;
`endif
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus random traffic,
// checked by a monitor against an array model of the architectural registers.
module tb_regfile;
  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic [4:0]   rs_num, rt_num, rd_num;
  logic [W-1:0] rd_data;
  logic         rd_we;
  logic [W-1:0] rs_data, rt_data;

  regfile dut (
    .clock   (clock),
    .reset   (reset),
    .rs_num  (rs_num),
    .rt_num  (rt_num),
    .rd_num  (rd_num),
    .rd_data (rd_data),
    .rd_we   (rd_we),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  // clock / reset
  initial clock = 1'b0;
  always #10 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  // reference model
  logic [W-1:0] model [32];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [W-1:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rd_we && !reset && rd_num != 5'd0 && idx == rd_num) return rd_data;
`endif
    return model[idx];
  endfunction

  // scoreboard
  logic [W-1:0] exp_q [$];
  int           kind_q [$];   // 0: rs/rt pair, 1: ALU add result
  string        name_q [$];
  event         sample_ev;

  task automatic compare(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, expv);
  endtask

  initial begin : monitor
    forever begin
      @(sample_ev);
      #1;
      while (kind_q.size() > 0) begin
        int k;
        string nm;
        k  = kind_q.pop_front();
        nm = name_q.pop_front();
        if (k == 0) begin
          if (exp_q.size() < 2) begin
            n_checks++;
            $display("FAIL %s: scoreboard underflow, got %0d entries, expected 2", nm, exp_q.size());
          end else begin
            compare({nm, ".rs"}, rs_data, exp_q.pop_front());
            compare({nm, ".rt"}, rt_data, exp_q.pop_front());
          end
        end else begin
          compare({nm, ".add"}, rs_data + rt_data, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic check_reads(input string nm);
    kind_q.push_back(0);
    name_q.push_back(nm);
    exp_q.push_back(exp_read(rs_num));
    exp_q.push_back(exp_read(rt_num));
    ->sample_ev;
    #2;
  endtask

  task automatic check_add(input string nm);
    kind_q.push_back(1);
    name_q.push_back(nm);
    exp_q.push_back(exp_read(rs_num) + exp_read(rt_num));
    ->sample_ev;
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset && rd_we && rd_num != 5'd0) model[rd_num] = rd_data;
    @(negedge clock);
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [W-1:0] val);
    rd_we = 1'b1; rd_num = idx; rd_data = val;
    tick();
    rd_we = 1'b0;
  endtask

  // stimulus
  initial begin : driver
    for (int i = 0; i < 32; i++) model[i] = 'x;
    reset = 1'b0; rs_num = '0; rt_num = '0; rd_num = '0; rd_data = '0; rd_we = 1'b0;
    #3;

    // Scribble, then reset pulse with no clock edge in between.
    @(negedge clock);
    write_reg(5'd1, 32'h1111_1111);
    write_reg(5'd31, 32'h3131_3131);
    #1;
    set_reset(1'b1);
    #1;
    set_reset(1'b0);
    rs_num = 5'd0;  rt_num = 5'd1;  check_reads("reset_async_0_1");
    rs_num = 5'd31; rt_num = 5'd0;  check_reads("reset_async_31_0");
    rs_num = 5'd1;  rt_num = 5'd31; check_reads("reset_async_1_31");
    @(negedge clock);

    // r8=8, r9=4, add -> 12
    write_reg(5'd8, 32'd8);
    write_reg(5'd9, 32'd4);
    rs_num = 5'd8; rt_num = 5'd9;
    check_reads("r8_r9");
    check_add("alu_add_12");

    // write to r0 discarded
    write_reg(5'd0, 32'hDEAD_BEEF);
    rs_num = 5'd0; rt_num = 5'd0; check_reads("r0_write_discard");

    // rd_we=0 changes nothing
    rd_we = 1'b0; rd_num = 5'd5; rd_data = 32'd7;
    tick();
    rs_num = 5'd5; rt_num = 5'd8; check_reads("we0_no_change");

    // same-cycle read of the register being written
    write_reg(5'd3, 32'd1);
    rd_we = 1'b1; rd_num = 5'd3; rd_data = 32'd2; rs_num = 5'd3; rt_num = 5'd3;
    check_reads("r3_before_edge");
    tick();
    rd_we = 1'b0;
    check_reads("r3_after_edge");

    // reset mid-cycle during a write of r31
    write_reg(5'd31, 32'h8000_0000);
    rd_we = 1'b1; rd_num = 5'd31; rd_data = 32'h4000_0000; rs_num = 5'd31; rt_num = 5'd3;
    check_reads("r31_before_reset");
    set_reset(1'b1);
    check_reads("r31_reset_immediate");
    tick();
    check_reads("r31_reset_over_edge");
    set_reset(1'b0);
    rd_we = 1'b0;
    tick();
    check_reads("r31_after_deassert");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rd_we   = ($urandom_range(0, 3) != 0);
      rd_num  = 5'($urandom_range(0, 31));
      rd_data = $urandom;
      rs_num  = ($urandom_range(0, 4) == 0) ? rd_num : 5'($urandom_range(0, 31));
      rt_num  = ($urandom_range(0, 4) == 0) ? rd_num : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) set_reset(1'b1);
      check_reads("rand_pre");
      tick();
      if (reset) begin
        check_reads("rand_in_reset");
        set_reset(1'b0);
      end
    end

    // final sweep of every register
    rd_we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs_num = 5'(i); rt_num = 5'(31 - i);
      check_reads("final_sweep");
    end

    #5;
    if (exp_q.size() != 0 || kind_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
